// File: rtl/button_conditioner.sv
// Front-panel button conditioning: 2-FF sync + ck35 debounce per button, then
// short/long MAGIC press classification timed by n_int frame edges.

module button_debounce #(
    parameter int DEBOUNCE_TICKS = 3500
) (
    input  logic clk28,
    input  logic rst,
    input  logic ck35,
    input  logic n_raw,
    output logic deb
);
    localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_TICKS - 1);

    logic          ff1, ff2;
    logic          s;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk28 or posedge rst) begin
        if (rst) begin
            ff1 <= 1'b1;
            ff2 <= 1'b1;
        end else begin
            ff1 <= n_raw;
            ff2 <= ff1;
        end
    end

    assign s = ~ff2;

    // deb only moves once the synced level has disagreed for DEBOUNCE_TICKS strobes
    always_ff @(posedge clk28 or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            deb <= 1'b0;
        end else if (s == deb) begin
            cnt <= '0;
        end else if (ck35) begin
            if (cnt == LAST) begin
                deb <= s;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module button_conditioner #(
    parameter int DEBOUNCE_TICKS = 3500,
    parameter int LONG_FRAMES    = 100,
    parameter int STRETCH_FRAMES = 2
) (
    input  logic clk28,
    input  logic rst,
    input  logic ck35,
    input  logic n_int,
    input  logic n_magic_raw,
    input  logic n_pause_raw,
    output logic magic_button,
    output logic pause_button,
    output logic reboot_req
);
    localparam int NUM_BTN = 2;
    localparam int FW      = $clog2(LONG_FRAMES + 1);
    localparam logic [FW-1:0] F_LONG    = FW'(LONG_FRAMES);
    localparam logic [FW-1:0] F_STRETCH = FW'(STRETCH_FRAMES);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PRESSED = 2'd1;
    localparam logic [1:0] ST_LONG    = 2'd2;
    localparam logic [1:0] ST_STRETCH = 2'd3;

    logic [NUM_BTN-1:0] n_raw_bus;
    logic [NUM_BTN-1:0] deb;
    logic               deb_magic, deb_pause, deb_magic_d;
    logic               n_int_d;
    logic               frame, press, rel;
    logic [1:0]         state;
    logic [FW-1:0]      fcnt, fcnt_inc;

    assign n_raw_bus = {n_pause_raw, n_magic_raw};

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
        button_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_deb (
            .clk28 (clk28),
            .rst   (rst),
            .ck35  (ck35),
            .n_raw (n_raw_bus[g]),
            .deb   (deb[g])
        );
    end

    assign deb_magic = deb[0];
    assign deb_pause = deb[1];

    assign frame    = n_int_d & ~n_int;
    assign press    = deb_magic & ~deb_magic_d;
    assign rel      = ~deb_magic & deb_magic_d;
    assign fcnt_inc = fcnt + 1'b1;

    always_ff @(posedge clk28 or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            fcnt         <= '0;
            magic_button <= 1'b0;
            pause_button <= 1'b0;
            reboot_req   <= 1'b0;
            n_int_d      <= 1'b0;
            deb_magic_d  <= 1'b0;
        end else begin
            pause_button <= deb_pause;
            n_int_d      <= n_int;
            deb_magic_d  <= deb_magic;
            reboot_req   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (press) begin
                        state <= ST_PRESSED;
                        fcnt  <= '0;
                    end
                end
                ST_PRESSED: begin
                    // the long-press frame takes priority over a coincident release
                    if (frame && fcnt_inc == F_LONG) begin
                        reboot_req <= 1'b1;
                        state      <= ST_LONG;
                        fcnt       <= '0;
                    end else if (rel) begin
                        state        <= ST_STRETCH;
                        fcnt         <= '0;
                        magic_button <= 1'b1;
                    end else if (frame) begin
                        fcnt <= fcnt_inc;
                    end
                end
                ST_LONG: begin
                    // level test so a release that coincided with the long frame still exits
                    if (!deb_magic) state <= ST_IDLE;
                end
                ST_STRETCH: begin
                    if (frame) begin
                        if (fcnt_inc == F_STRETCH) begin
                            magic_button <= 1'b0;
                            state        <= ST_IDLE;
                            fcnt         <= '0;
                        end else begin
                            fcnt <= fcnt_inc;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
